// File: rtl/ifetch_controller.sv
// Instruction fetch sequencer: owns PCF and a one-entry instruction buffer, handshakes a variable-latency imem.
// One request outstanding; a redirect during an in-flight request drops that request's response.
module ifetch_controller #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h00000000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrF,
    output logic            InstrValidF,
    output logic            StallF
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            instr_vld_q;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] target_al;

    assign target_al = {PCTargetE[XLEN-1:2], PCTargetE[1:0] & 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (imem_ack && !PCSrcE) begin
                    state_nxt = HOLD;
                end else if (!imem_ack && PCSrcE) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                if (PCSrcE || !StallD) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == REQ) || (state == DISCARD);
    end

    // PCF is never changed while a handshake is open, so it is also the in-flight address in DISCARD.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            instr_vld_q <= 1'b0;
            pend_target <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PCSrcE) begin
                        pc_q <= target_al;
                    end
                end
                REQ: begin
                    if (imem_ack && PCSrcE) begin
                        pc_q <= target_al;
                    end else if (imem_ack) begin
                        instr_q     <= imem_rdata;
                        instr_vld_q <= 1'b1;
                    end else if (PCSrcE) begin
                        pend_target <= target_al;
                    end
                end
                DISCARD: begin
                    if (PCSrcE) begin
                        pend_target <= target_al;
                    end
                    if (imem_ack) begin
                        pc_q <= PCSrcE ? target_al : pend_target;
                    end
                end
                HOLD: begin
                    if (PCSrcE) begin
                        pc_q        <= target_al;
                        instr_q     <= NOP_INSTR;
                        instr_vld_q <= 1'b0;
                    end else if (!StallD) begin
                        pc_q        <= pc_q + XLEN'(4);
                        instr_q     <= NOP_INSTR;
                        instr_vld_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign PCF         = pc_q;
    assign InstrF      = instr_q;
    assign InstrValidF = instr_vld_q;
    assign StallF      = ~instr_vld_q;

endmodule
